settings_ram_regs: RTL and testbench



---
 rtl/settings_ram_regs.sv | 70 +++++++
 tb/tb_settings_ram_regs.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/settings_ram_regs.sv
// settings_ram_regs: five 32-bit user-setting registers with parameter defaults.
// All fields load together on a write strobe; reads come straight off the registers.
module settings_ram_regs #(
  parameter logic [31:0] DEF_MAX_ROW   = 32'd5,
  parameter logic [31:0] DEF_MAX_COL   = 32'd5,
  parameter logic [31:0] DEF_DATA_MIN  = 32'd0,
  parameter logic [31:0] DEF_DATA_MAX  = 32'd9,
  parameter logic [31:0] DEF_COUNTDOWN = 32'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] set_max_row,
  input  logic [31:0] set_max_col,
  input  logic [31:0] data_min,
  input  logic [31:0] data_max,
  input  logic [31:0] set_countdown_time,
  output logic [31:0] rd_max_row,
  output logic [31:0] rd_max_col,
  output logic [31:0] rd_data_min,
  output logic [31:0] rd_data_max,
  output logic [31:0] rd_countdown_time
);

  logic [31:0] max_row_q,   max_row_d;
  logic [31:0] max_col_q,   max_col_d;
  logic [31:0] data_min_q,  data_min_d;
  logic [31:0] data_max_q,  data_max_d;
  logic [31:0] countdown_q, countdown_d;

  // Next-state: load the whole image on a write, otherwise hold.
  always_comb begin
    max_row_d   = max_row_q;
    max_col_d   = max_col_q;
    data_min_d  = data_min_q;
    data_max_d  = data_max_q;
    countdown_d = countdown_q;
    if (wr_en) begin
      max_row_d   = set_max_row;
      max_col_d   = set_max_col;
      data_min_d  = data_min;
      data_max_d  = data_max;
      countdown_d = set_countdown_time;
    end
  end

  // Storage registers; reset takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_row_q   <= DEF_MAX_ROW;
      max_col_q   <= DEF_MAX_COL;
      data_min_q  <= DEF_DATA_MIN;
      data_max_q  <= DEF_DATA_MAX;
      countdown_q <= DEF_COUNTDOWN;
    end else begin
      max_row_q   <= max_row_d;
      max_col_q   <= max_col_d;
      data_min_q  <= data_min_d;
      data_max_q  <= data_max_d;
      countdown_q <= countdown_d;
    end
  end

  assign rd_max_row        = max_row_q;
  assign rd_max_col        = max_col_q;
  assign rd_data_min       = data_min_q;
  assign rd_data_max       = data_max_q;
  assign rd_countdown_time = countdown_q;

endmodule

// File: tb/tb_settings_ram_regs.sv
// tb_settings_ram_regs: table-driven checks plus a few multi-cycle sequences.
module tb_settings_ram_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] set_max_row, set_max_col, data_min, data_max, set_countdown_time;
  logic [31:0] rd_max_row, rd_max_col, rd_data_min, rd_data_max, rd_countdown_time;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  settings_ram_regs dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_en             (wr_en),
    .set_max_row       (set_max_row),
    .set_max_col       (set_max_col),
    .data_min          (data_min),
    .data_max          (data_max),
    .set_countdown_time(set_countdown_time),
    .rd_max_row        (rd_max_row),
    .rd_max_col        (rd_max_col),
    .rd_data_min       (rd_data_min),
    .rd_data_max       (rd_data_max),
    .rd_countdown_time (rd_countdown_time)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] din [5];
    logic [31:0] exp [5];
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic w,
                              logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              logic [31:0] d, logic [31:0] e,
                              logic [31:0] ea, logic [31:0] eb, logic [31:0] ec,
                              logic [31:0] ed, logic [31:0] ee);
    vec_t v;
    v.name = n; v.rst_n = r; v.wr_en = w;
    v.din[0] = a;  v.din[1] = b;  v.din[2] = c;  v.din[3] = d;  v.din[4] = e;
    v.exp[0] = ea; v.exp[1] = eb; v.exp[2] = ec; v.exp[3] = ed; v.exp[4] = ee;
    return v;
  endfunction

  task automatic drive(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [31:0] e);
    rst_n = r; wr_en = w;
    set_max_row = a; set_max_col = b; data_min = c; data_max = d; set_countdown_time = e;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                           input logic [31:0] ed, input logic [31:0] ee);
    check1({name, ".max_row"},   rd_max_row,        ea);
    check1({name, ".max_col"},   rd_max_col,        eb);
    check1({name, ".data_min"},  rd_data_min,       ec);
    check1({name, ".data_max"},  rd_data_max,       ed);
    check1({name, ".countdown"}, rd_countdown_time, ee);
  endtask

  initial begin
    // One entry per rising edge: inputs driven before it, outputs checked after it.
    vecs.push_back(mk("rst1", 0, 0, 0, 0, 0, 0, 0,                 5, 5, 0, 9, 10));
    vecs.push_back(mk("rst2", 0, 0, 0, 0, 0, 0, 0,                 5, 5, 0, 9, 10));
    vecs.push_back(mk("idle", 1, 0, 7, 7, 7, 7, 7,                 5, 5, 0, 9, 10));
    vecs.push_back(mk("row32", 1, 1, 32, 5, 0, 9, 10,              32, 5, 0, 9, 10));
    vecs.push_back(mk("full", 1, 1, 12, 20, 32'hFFFFFF00, 65535, 15,
                      12, 20, 32'hFFFFFF00, 65535, 15));
    vecs.push_back(mk("hold0", 1, 0, 0, 0, 0, 0, 0,                12, 20, 32'hFFFFFF00, 65535, 15));
    vecs.push_back(mk("rstwin", 0, 1, 1, 1, 1, 1, 1,               5, 5, 0, 9, 10));
    vecs.push_back(mk("b2b7", 1, 1, 5, 5, 0, 9, 7,                 5, 5, 0, 9, 7));
    vecs.push_back(mk("b2b13", 1, 1, 5, 5, 0, 9, 13,               5, 5, 0, 9, 13));
    vecs.push_back(mk("zeros", 1, 1, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0));
    vecs.push_back(mk("ones", 1, 1, '1, '1, '1, '1, '1,            '1, '1, '1, '1, '1));
    vecs.push_back(mk("glitch", 1, 0, 32'h1234, 3, 4, 5, 6,        '1, '1, '1, '1, '1));
    vecs.push_back(mk("mixed", 1, 1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0001, 32'hA5A5_5A5A,
                      32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0001, 32'hA5A5_5A5A));

    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].wr_en, vecs[i].din[0], vecs[i].din[1],
            vecs[i].din[2], vecs[i].din[3], vecs[i].din[4]);
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].exp[0], vecs[i].exp[1], vecs[i].exp[2],
                vecs[i].exp[3], vecs[i].exp[4]);
      @(negedge clk);
    end

    // Pulse cycle still shows the old value; new value appears after the edge.
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(1, 1, 32, 5, 0, 9, 10);
    #1;
    check1("pulse.before_edge.max_row", rd_max_row, 32'd5);
    @(posedge clk); #1;
    check_all("pulse.after_edge", 32, 5, 0, 9, 10);
    @(negedge clk);

    // Full write then ten idle cycles with changing inputs.
    drive(1, 1, 12, 20, 32'hFFFFFF00, 65535, 15);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 32'(c), 32'(c * 3), 32'(~c), 32'(c + 100), 0);
      @(posedge clk); @(negedge clk);
    end
    check_all("hold10", 12, 20, 32'hFFFFFF00, 65535, 15);

    // wr_en held high: outputs track inputs one edge later.
    for (int c = 1; c <= 4; c++) begin
      drive(1, 1, 32'(c), 32'(c + 1), 32'(c + 2), 32'(c + 3), 32'(c + 4));
      #1;
      if (c > 1) check1("stream.lag.max_row", rd_max_row, 32'(c - 1));
      @(posedge clk); #1;
      check1("stream.max_row", rd_max_row, 32'(c));
      check1("stream.countdown", rd_countdown_time, 32'(c + 4));
      @(negedge clk);
    end

    // Reset mid-sequence, then an immediate write with no recovery cycle.
    drive(0, 0, 99, 99, 99, 99, 99);
    @(posedge clk); #1;
    check_all("midrst", 5, 5, 0, 9, 10);
    @(negedge clk);
    drive(1, 1, 40, 41, 42, 43, 44);
    @(posedge clk); #1;
    check_all("postrst_write", 40, 41, 42, 43, 44);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
